// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side consumer for an async FIFO, running entirely in the read clock
//   domain. It issues read_enable pulses, absorbs the FIFO's one-cycle read
//   latency, and re-presents the words as a valid/ready stream through a
//   2-entry buffer with burst framing (out_last every BURST_LEN transfers).
//
// Handshake: a word moves downstream on every cycle where out_valid and
//   out_ready are both 1. While out_valid=1 and out_ready=0, out_data,
//   out_last and out_valid hold their values.
//
// Ports:
//   read_clk          sole clock
//   reset             synchronous, active-high reset
//   enable            1 = fetch from FIFO, 0 = stop fetching and drain
//   fifo_empty        FIFO empty flag
//   fifo_data         FIFO read data
//   fifo_data_valid   FIFO read data valid (one cycle after read_enable)
//   fifo_underflow    FIFO underflow flag
//   fifo_read_enable  read strobe to the FIFO
//   out_data          head-of-buffer word (0 when the buffer is empty)
//   out_valid         buffer holds at least one word
//   out_ready         downstream accept
//   out_last          head word is the last word of a frame
//   busy              FSM is not IDLE
//   error             sticky protocol error
//   clear_error       single-cycle clear of error (a same-cycle set wins)
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//   word_count        accepted transfers, saturating; present only when
//                     FIFO_READER_STATS_EN is defined
//
// Optional feature macro: FIFO_READER_STATS_EN

module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 8
) (
    input  logic                  read_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_data_valid,
    input  logic                  fifo_underflow,
    output logic                  fifo_read_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  error,
    input  logic                  clear_error,
`ifdef FIFO_READER_STATS_EN
    output logic [31:0]           word_count,
`endif
    output logic [1:0]            dbg_state
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [1:0]              r_occ;
    logic                    r_pend;
    logic [DATA_WIDTH-1:0]   r_buf0;
    logic [DATA_WIDTH-1:0]   r_buf1;
    logic [BW-1:0]           r_beat;
    logic                    r_error;
    logic                    w_rd_en;
    logic                    w_pop;
    logic                    w_cap;
    logic                    w_err_set;
    logic                    w_enter_idle;
    logic [1:0]              w_inflight;

    // Words already buffered plus the one still in flight from the FIFO;
    // never read more than the 2-entry buffer can absorb.
    assign w_inflight = r_occ + {1'b0, r_pend};

    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_RUN;
            end
            S_RUN: begin
                w_rd_en = !fifo_empty && (w_inflight < 2'd2);
                if (!enable) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (!r_pend && (r_occ == 2'd0)) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_idle = (r_state != S_IDLE) && (w_next_state == S_IDLE);
    assign w_pop        = (r_occ != 2'd0) && out_ready;
    assign w_cap        = r_pend && fifo_data_valid;
    assign w_err_set    = (fifo_data_valid && !r_pend) ||
                          (r_pend && !fifo_data_valid) ||
                          fifo_underflow;

    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_occ   <= 2'd0;
            r_pend  <= 1'b0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_beat  <= '0;
            r_error <= 1'b0;
        end else begin
            r_pend <= w_rd_en;

            // r_buf0 is always the head; r_buf1 is only meaningful at occ=2.
            if (w_pop && w_cap) begin
                if (r_occ == 2'd1) begin
                    r_buf0 <= fifo_data;
                end else begin
                    r_buf0 <= r_buf1;
                    r_buf1 <= fifo_data;
                end
            end else if (w_pop) begin
                r_buf0 <= r_buf1;
                r_occ  <= r_occ - 2'd1;
            end else if (w_cap) begin
                if (r_occ == 2'd0) r_buf0 <= fifo_data;
                else               r_buf1 <= fifo_data;
                r_occ <= r_occ + 2'd1;
            end

            if (w_enter_idle) begin
                r_beat <= '0;
            end else if (w_pop) begin
                r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
            end

            if (w_err_set)        r_error <= 1'b1;
            else if (clear_error) r_error <= 1'b0;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [31:0] r_word_count;

    always_ff @(posedge read_clk) begin
        if (reset) begin
            r_word_count <= '0;
        end else if (w_pop && (r_word_count != 32'hFFFF_FFFF)) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`endif

    assign fifo_read_enable = w_rd_en;
    assign out_valid        = (r_occ != 2'd0);
    assign out_data         = out_valid ? r_buf0 : '0;
    assign out_last         = out_valid && (r_beat == LAST_BEAT);
    assign busy             = (r_state != S_IDLE);
    assign error            = r_error;
    assign dbg_state        = r_state;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader (BURST_LEN=4). A queue-based FIFO
// environment answers the reader's read strobes one cycle later, and a
// behavioural model (word queue, in-flight flag, frame position) predicts
// every output each cycle. Directed phases pin the model with literal
// expectations; a randomized phase mixes traffic, back-pressure and faults.

module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int BL = 4;

    logic          read_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_data_valid = 1'b0;
    logic          fifo_underflow = 1'b0;
    logic          fifo_read_enable;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          error;
    logic          clear_error = 1'b0;
    logic [1:0]    dbg_state;
`ifdef FIFO_READER_STATS_EN
    logic [31:0]   word_count;
`endif

    always #5 read_clk = ~read_clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .read_clk         (read_clk),
        .reset            (reset),
        .enable           (enable),
        .fifo_empty       (fifo_empty),
        .fifo_data        (fifo_data),
        .fifo_data_valid  (fifo_data_valid),
        .fifo_underflow   (fifo_underflow),
        .fifo_read_enable (fifo_read_enable),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .busy             (busy),
        .error            (error),
        .clear_error      (clear_error),
`ifdef FIFO_READER_STATS_EN
        .word_count       (word_count),
`endif
        .dbg_state        (dbg_state)
    );

    // Stimulus knobs, applied to the DUT on the falling edge.
    bit k_reset = 1, k_enable = 0, k_ready = 0, k_clear = 0, k_underflow = 0;
    bit k_spur = 0, k_drop = 0;

    // FIFO environment
    logic [DW-1:0] fifo_q[$];
    bit            env_dv = 0;
    logic [DW-1:0] env_d = '0;

    // Behavioural model: 0 idle, 1 fetching, 2 draining
    int            m_mode = 0;
    logic [DW-1:0] exp_q[$];
    bit            m_pend = 0;
    int            m_beat = 0;
    bit            m_err = 0;
    longint        m_cnt = 0;
    bit            exp_rd;

    // Logs
    logic [DW-1:0] xfer_q[$];
    bit            last_q[$];
    int            xfer_cyc[$];
    int            rd_cyc[$];
    int            dut_rd_count = 0;
    int            cyc = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        xfer_q.delete(); last_q.delete(); xfer_cyc.delete(); rd_cyc.delete();
    endtask

    task automatic step();
        bit dut_rd, pop, cap, eset, drain_done;
        logic [DW-1:0] head;
        cyc++;
        @(negedge read_clk);
        reset          = k_reset;
        enable         = k_enable;
        out_ready      = k_ready;
        clear_error    = k_clear;
        fifo_underflow = k_underflow;
        fifo_empty     = (fifo_q.size() == 0);
        fifo_data_valid = env_dv;
        fifo_data      = env_dv ? env_d : DW'($urandom);
        if (k_spur) begin
            fifo_data_valid = 1'b1;
            fifo_data       = DW'($urandom);
        end
        #1;
        exp_rd = (m_mode == 1) && !fifo_empty && (exp_q.size() + int'(m_pend) < 2);
        chk("fifo_read_enable", fifo_read_enable, exp_rd);
        chk("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
        chk("out_last", out_last, (exp_q.size() != 0) && (m_beat == BL - 1));
        chk("busy", busy, m_mode != 0);
        chk("error", error, m_err);
`ifdef FIFO_READER_STATS_EN
        chk("word_count", word_count, m_cnt[31:0]);
`endif
        dut_rd = fifo_read_enable;
        if (dut_rd) begin
            dut_rd_count++;
            rd_cyc.push_back(cyc);
        end
        @(posedge read_clk);
        pop        = (exp_q.size() != 0) && out_ready;
        cap        = m_pend && fifo_data_valid;
        eset       = (fifo_data_valid && !m_pend) || (m_pend && !fifo_data_valid) || fifo_underflow;
        drain_done = !m_pend && (exp_q.size() == 0);
        if (reset) begin
            m_mode = 0; exp_q.delete(); m_pend = 0; m_beat = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (pop) begin
                head = exp_q.pop_front();
                xfer_q.push_back(head);
                last_q.push_back(m_beat == BL - 1);
                xfer_cyc.push_back(cyc);
                m_beat = (m_beat + 1) % BL;
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            end
            if (cap) exp_q.push_back(fifo_data);
            case (m_mode)
                0: if (enable) m_mode = 1;
                1: if (!enable) m_mode = 2;
                default: if (drain_done) begin m_mode = 0; m_beat = 0; end
            endcase
            m_pend = exp_rd;
            if (eset) m_err = 1;
            else if (clear_error) m_err = 0;
        end
        env_dv = 0;
        if (dut_rd && fifo_q.size() > 0) begin
            env_d  = fifo_q.pop_front();
            env_dv = !k_drop;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_xfers(input int n, input int limit, input string name);
        int k = 0;
        while (xfer_q.size() < n && k < limit) begin step(); k++; end
        if (xfer_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d transfers expected %0d", name, xfer_q.size(), n);
        end
    endtask

    task automatic wait_idle(input int limit, input string name);
        int k = 0;
        while (m_mode != 0 && k < limit) begin step(); k++; end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle timeout: busy got %0b expected 0", name, busy);
        end
    endtask

    logic [DW-1:0] lit3[3] = '{16'hAAAA, 16'h5555, 16'hFFFF};
    logic [DW-1:0] ten[$];
    int            rd0;

    initial begin
        // Reset
        k_reset = 1; run(3);
        #2;
        chk("rst fifo_read_enable", fifo_read_enable, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst busy", busy, 0);
        chk("rst error", error, 0);
        chk("rst out_data", out_data, 0);
        k_reset = 0;

        // Three words, out_ready=1: each word appears 2 cycles after its read
        clear_logs();
        rd0 = dut_rd_count;
        foreach (lit3[i]) fifo_q.push_back(lit3[i]);
        k_enable = 1; k_ready = 1;
        wait_xfers(3, 30, "three_words");
        run(3);
        chk("three reads", dut_rd_count - rd0, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < xfer_q.size()) chk("three data", xfer_q[i], lit3[i]);
            if (i < xfer_q.size() && i < rd_cyc.size())
                chk("three latency", xfer_cyc[i] - rd_cyc[i], 2);
        end
        chk("three error", error, 0);

        // Back-pressure: 10 queued words, only 2 reads until released
        clear_logs();
        ten.delete();
        for (int i = 0; i < 10; i++) ten.push_back(DW'(16'h1000 + i * 16'h0111));
        k_ready = 0;
        foreach (ten[i]) fifo_q.push_back(ten[i]);
        rd0 = dut_rd_count;
        run(15);
        #2;
        chk("bp reads", dut_rd_count - rd0, 2);
        chk("bp model occ", exp_q.size(), 2);
        chk("bp out_valid", out_valid, 1);
        chk("bp out_data", out_data, 16'h1000);
        k_ready = 1;
        wait_xfers(10, 60, "bp_release");
        for (int i = 0; i < 10; i++)
            if (i < xfer_q.size()) chk("bp order", xfer_q[i], ten[i]);

        // Framing: 9 words -> last on 4th and 8th; re-enable restarts frame
        k_enable = 0; wait_idle(20, "frame_pre");
        clear_logs();
        k_enable = 1;
        for (int i = 0; i < 9; i++) fifo_q.push_back(DW'(16'h2000 + i));
        wait_xfers(9, 60, "frame9");
        for (int i = 0; i < 9; i++)
            if (i < last_q.size()) chk("frame9 last", last_q[i], (i == 3 || i == 7));
        k_enable = 0; wait_idle(20, "frame_mid");
        clear_logs();
        k_enable = 1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'h3000 + i));
        wait_xfers(4, 40, "frame4");
        for (int i = 0; i < 4; i++)
            if (i < last_q.size()) chk("frame restart last", last_q[i], (i == 3));

        // Drain: buffer full, enable dropped, busy holds until words accepted
        clear_logs();
        k_ready = 0;
        for (int i = 0; i < 5; i++) fifo_q.push_back(DW'(16'h4000 + i));
        run(6);
        k_enable = 0;
        rd0 = dut_rd_count;
        run(5);
        #2;
        chk("drain busy", busy, 1);
        chk("drain no reads", dut_rd_count - rd0, 0);
        k_ready = 1;
        wait_idle(20, "drain");
        chk("drain words", xfer_q.size(), 2);
        chk("drain no reads after", dut_rd_count - rd0, 0);
        fifo_q.delete();

        // Error injection while idle
        k_spur = 1; step(); k_spur = 0;
        #2;
        chk("spur error", error, 1);
        chk("spur dropped", out_valid, 0);
        k_clear = 1; step(); k_clear = 0;
        #2;
        chk("clear error", error, 0);
        k_underflow = 1; step(); k_underflow = 0;
        #2;
        chk("underflow error", error, 1);
        k_underflow = 1; k_clear = 1; step(); k_underflow = 0; k_clear = 0;
        #2;
        chk("set wins over clear", error, 1);
        k_clear = 1; step(); k_clear = 0;

        // Randomized traffic with faults and occasional resets
        for (int i = 0; i < 3000; i++) begin
            k_enable    = ($urandom_range(0, 15) != 0);
            k_ready     = ($urandom_range(0, 3) != 0);
            k_spur      = ($urandom_range(0, 99) == 0);
            k_drop      = ($urandom_range(0, 99) == 0);
            k_underflow = ($urandom_range(0, 149) == 0);
            k_clear     = ($urandom_range(0, 29) == 0);
            k_reset     = ($urandom_range(0, 299) == 0);
            if (fifo_q.size() < 20 && $urandom_range(0, 1) == 1) fifo_q.push_back(DW'($urandom));
            step();
        end
        k_spur = 0; k_drop = 0; k_underflow = 0; k_clear = 0;

        // 300 accepted words after reset, then reset mid-stream
        k_reset = 1; step(); k_reset = 0;
        fifo_q.delete();
        run(2);
        clear_logs();
        k_enable = 1; k_ready = 1;
        begin
            int k = 0;
            while (xfer_q.size() < 300 && k < 2000) begin
                if (fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
                step();
                k++;
            end
        end
        #2;
        chk("stream 300 transfers", xfer_q.size(), 300);
`ifdef FIFO_READER_STATS_EN
        chk("word_count 300", word_count, 300);
`endif
        k_reset = 1; step(); k_reset = 0;
        #2;
        chk("midrst fifo_read_enable", fifo_read_enable, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_last", out_last, 0);
        chk("midrst busy", busy, 0);
        chk("midrst out_data", out_data, 0);
        chk("midrst error", error, 0);
`ifdef FIFO_READER_STATS_EN
        chk("midrst word_count", word_count, 0);
`endif
        k_enable = 0;
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
